// File: rtl/data_mem_param_if.sv
// Access bus for data_mem_param: request signals in from the master, read data and status back.
interface data_mem_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              Enable;
    logic              Write_en;
    logic              Clear;
    logic [ADDR_W-1:0] Address_port;
    logic [DATA_W-1:0] Input_data;
    logic [DATA_W-1:0] Output_data;
    logic              Rd_valid;
    logic              Ready;

    modport master (
        output Enable, Write_en, Clear, Address_port, Input_data,
        input  Output_data, Rd_valid, Ready
    );

    modport slave (
        input  Enable, Write_en, Clear, Address_port, Input_data,
        output Output_data, Rd_valid, Ready
    );
endinterface

// File: rtl/data_mem_param.sv
// Single-port word memory with a clear sweep (INIT) and 1-cycle registered reads (IDLE).
module data_mem_param #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    data_mem_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, IDLE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_out;
    logic              r_rd_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_access;
    logic w_wr;
    logic w_rd;
    logic w_last;

    // r_ready tracks IDLE except in the first cycle after a reset that lands in IDLE,
    // so accesses are only taken once Ready is actually visible.
    assign w_access = bus.Enable && !bus.Clear && r_ready;
    assign w_wr     = w_access && bus.Write_en;
    assign w_rd     = w_access && !bus.Write_en;
    assign w_last   = (r_cnt == {ADDR_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CLEAR_ON_RESET ? INIT : IDLE;
            r_cnt      <= '0;
            r_out      <= '0;
            r_rd_valid <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_rd_valid <= w_rd;
            if (w_rd)
                r_out <= r_mem[bus.Address_port];

            if (bus.Clear) begin
                r_state <= INIT;
                r_cnt   <= '0;
                r_ready <= 1'b0;
            end else if (r_state == INIT) begin
                if (w_last) begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_ready <= 1'b1;
            end
        end
    end

    // No reset on the array: contents come only from the sweep or from writes.
    always_ff @(posedge clk) begin
        if (r_state == INIT)
            r_mem[r_cnt] <= '0;
        else if (w_wr)
            r_mem[bus.Address_port] <= bus.Input_data;
    end

    assign bus.Output_data = r_out;
    assign bus.Rd_valid    = r_rd_valid;
    assign bus.Ready       = r_ready;
endmodule

// File: tb/tb_data_mem_param.sv
// Scoreboard bench: default-config DUT plus a CLEAR_ON_RESET=0, 12x16 DUT.
module tb_data_mem_param;
    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    data_mem_param_if #(.DATA_W(8),  .ADDR_W(8)) ifa();
    data_mem_param_if #(.DATA_W(12), .ADDR_W(4)) ifb();

    data_mem_param dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));
    data_mem_param #(.DATA_W(12), .ADDR_W(4), .CLEAR_ON_RESET(1'b0))
        dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb));

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem_a [256];
    logic [7:0]  q_a [$];
    logic [7:0]  last_a, e_a;
    logic [11:0] mem_b [16];
    bit          wr_b [16];
    logic [11:0] q_b [$];
    logic [11:0] last_b, e_b;

    int          r;
    logic [7:0]  ad, d8;
    logic [3:0]  ab;
    logic [11:0] d12;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitors: pop on every Rd_valid, otherwise Output_data must hold.
    always @(negedge clk) begin
        if (!rst_a) last_a = '0;
        else if (ifa.Rd_valid) begin
            if (q_a.size() == 0) chk("a_spurious_rd_valid", ifa.Rd_valid, 0);
            else begin
                e_a = q_a.pop_front();
                chk("a_read", ifa.Output_data, e_a);
                last_a = e_a;
            end
        end else chk("a_hold", ifa.Output_data, last_a);
    end

    always @(negedge clk) begin
        if (!rst_b) last_b = '0;
        else if (ifb.Rd_valid) begin
            if (q_b.size() == 0) chk("b_spurious_rd_valid", ifb.Rd_valid, 0);
            else begin
                e_b = q_b.pop_front();
                chk("b_read", ifb.Output_data, e_b);
                last_b = e_b;
            end
        end else chk("b_hold", ifb.Output_data, last_b);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        ifa.Enable = 1'b0; ifa.Write_en = 1'b0; ifa.Clear = 1'b0;
    endtask

    task automatic a_zero_model();
        for (int i = 0; i < 256; i++) mem_a[i] = '0;
    endtask

    task automatic a_write(input logic [7:0] a, input logic [7:0] d);
        ifa.Enable = 1'b1; ifa.Write_en = 1'b1; ifa.Clear = 1'b0;
        ifa.Address_port = a; ifa.Input_data = d;
        mem_a[a] = d;
        cyc();
    endtask

    task automatic a_read(input logic [7:0] a);
        ifa.Enable = 1'b1; ifa.Write_en = 1'b0; ifa.Clear = 1'b0;
        ifa.Address_port = a;
        q_a.push_back(mem_a[a]);
        cyc();
    endtask

    task automatic a_clear();
        ifa.Clear = 1'b1; ifa.Enable = 1'b0; ifa.Write_en = 1'b0;
        cyc();
        ifa.Clear = 1'b0;
        a_zero_model();
    endtask

    // Counts negedges with Ready low before Ready rises; bounded.
    task automatic a_wait(input string nm, input int exp);
        int n = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (ifa.Ready === 1'b1) break;
            n++;
        end
        chk(nm, n, exp);
    endtask

    task automatic b_write(input logic [3:0] a, input logic [11:0] d);
        ifb.Enable = 1'b1; ifb.Write_en = 1'b1; ifb.Clear = 1'b0;
        ifb.Address_port = a; ifb.Input_data = d;
        mem_b[a] = d; wr_b[a] = 1'b1;
        cyc();
    endtask

    task automatic b_read(input logic [3:0] a);
        ifb.Enable = 1'b1; ifb.Write_en = 1'b0; ifb.Clear = 1'b0;
        ifb.Address_port = a;
        q_b.push_back(mem_b[a]);
        cyc();
    endtask

    initial begin
        a_idle(); ifa.Address_port = '0; ifa.Input_data = '0;
        ifb.Enable = 1'b0; ifb.Write_en = 1'b0; ifb.Clear = 1'b0;
        ifb.Address_port = '0; ifb.Input_data = '0;
        for (int i = 0; i < 16; i++) wr_b[i] = 1'b0;

        // Reset state and the power-up sweep
        repeat (3) cyc();
        chk("a_rst_ready", ifa.Ready, 0);
        chk("a_rst_rd_valid", ifa.Rd_valid, 0);
        chk("a_rst_out", ifa.Output_data, 0);
        rst_a = 1'b1;
        a_wait("a_init_sweep_len", 256);
        a_zero_model();

        // Back-to-back reads of swept memory, then write/read-after-write
        a_read(8'h00); a_read(8'h7F); a_read(8'hFF);
        a_write(8'h10, 8'hA5); a_read(8'h10);
        a_idle(); repeat (2) cyc();

        // Clear wipes written data
        a_write(8'hFF, 8'h3C); a_read(8'hFF);
        a_idle(); cyc();
        a_clear();
        a_wait("a_clear_sweep_len", 256);
        a_read(8'hFF);

        // Clear beats a simultaneous read; accesses ignored in INIT; Clear in INIT restarts
        a_write(8'h20, 8'h5A); a_read(8'h20);
        a_idle(); cyc();
        ifa.Clear = 1'b1; ifa.Enable = 1'b1; ifa.Write_en = 1'b0; ifa.Address_port = 8'h10;
        cyc();
        a_idle(); a_zero_model();
        chk("a_clear_read_ready", ifa.Ready, 0);
        ifa.Enable = 1'b1; ifa.Write_en = 1'b1; ifa.Address_port = 8'h05; ifa.Input_data = 8'h77;
        repeat (20) cyc();
        a_idle();
        repeat (30) cyc();
        a_clear();
        a_wait("a_clear_in_init_len", 256);
        a_read(8'h05); a_read(8'h10); a_read(8'h20);
        a_idle(); cyc();

        // Randomized traffic, with Write_en sometimes set while Enable is low
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 149));
            if (r == 0) begin
                a_clear();
                a_wait("a_rand_clear_len", 256);
                continue;
            end
            ad = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            d8 = 8'($urandom);
            ifa.Enable = ($urandom_range(0, 3) != 0);
            ifa.Write_en = 1'($urandom_range(0, 1));
            ifa.Address_port = ad; ifa.Input_data = d8;
            if (ifa.Enable && ifa.Write_en) mem_a[ad] = d8;
            else if (ifa.Enable) q_a.push_back(mem_a[ad]);
            cyc();
        end

        // Reset in the middle of a sweep, with nonzero Output_data beforehand
        a_write(8'h10, 8'hA5); a_read(8'h10);
        a_idle(); cyc();
        a_clear();
        repeat (100) cyc();
        rst_a = 1'b0;
        #1;
        chk("a_midsweep_rst_out", ifa.Output_data, 0);
        chk("a_midsweep_rst_ready", ifa.Ready, 0);
        chk("a_midsweep_rst_rd_valid", ifa.Rd_valid, 0);
        repeat (2) cyc();
        rst_a = 1'b1;
        a_wait("a_midsweep_rst_len", 256);

        // Reset lands on a pending read: no Rd_valid may come out of it
        a_write(8'h40, 8'h99);
        ifa.Enable = 1'b1; ifa.Write_en = 1'b0; ifa.Address_port = 8'h40;
        #2 rst_a = 1'b0;
        #1 a_idle();
        chk("a_midread_rst_rd_valid", ifa.Rd_valid, 0);
        repeat (2) cyc();
        rst_a = 1'b1;
        a_zero_model();
        a_wait("a_midread_rst_len", 256);
        a_read(8'h40);
        a_idle(); repeat (3) cyc();

        // Second configuration: no reset sweep
        chk("b_rst_ready", ifb.Ready, 0);
        chk("b_rst_out", ifb.Output_data, 0);
        rst_b = 1'b1;
        #1;
        chk("b_ready_before_edge", ifb.Ready, 0);
        cyc();
        chk("b_ready_after_edge", ifb.Ready, 1);
        b_write(4'hF, 12'hFFF); b_read(4'hF);
        for (int i = 0; i < 80; i++) begin
            ab = 4'($urandom_range(0, 15));
            d12 = 12'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                ifb.Enable = 1'b0; ifb.Write_en = 1'($urandom_range(0, 1));
                ifb.Address_port = ab; ifb.Input_data = d12;
                cyc();
            end else if (!wr_b[ab] || $urandom_range(0, 1) != 0) b_write(ab, d12);
            else b_read(ab);
        end
        ifb.Enable = 1'b0; ifb.Write_en = 1'b0;
        repeat (3) cyc();

        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
